// File: rtl/nand2cpu_pkg.sv
// rtl/nand2cpu_pkg.sv - shared ALU widths, opcodes and arbiter state encodings
package nand2cpu_pkg;

  localparam int ALU_W = 8;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;
  localparam logic [1:0] ALU_OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between requesters and the shared ALU arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 4
);
  import nand2cpu_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ALU_W-1:0] req_a;
  logic [NREQ*ALU_W-1:0] req_b;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ALU_W-1:0]      rsp_y;
  logic                  rsp_carry;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_carry, busy
  );

endinterface

// File: rtl/alu8.sv
// rtl/alu8.sv - 8-bit ALU; carry is bit 8 of the 9-bit result (borrow for SUB)
module alu8
  import nand2cpu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [ALU_W-1:0] y_o,
  output logic             carry_o
);
  logic [ALU_W:0] res;

  always_comb begin
    res = '0;
    case (op_i)
      ALU_OP_ADD: res = {1'b0, a_i} + {1'b0, b_i};
      ALU_OP_SUB: res = {1'b0, a_i} - {1'b0, b_i};
      ALU_OP_AND: res = {1'b0, a_i & b_i};
      default:    res = {1'b0, a_i | b_i};
    endcase
  end

  assign y_o     = res[ALU_W-1:0];
  assign carry_o = res[ALU_W];

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker scanning upward from last_grant+1
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_grant_i,
  output logic                    any_o,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic [NREQ-1:0]         grant_o
);
  localparam int IDW = $clog2(NREQ);

  int idx;

  // last_grant itself is visited last, which gives the rotation
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    grant_o  = '0;
    idx      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_grant_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_o && req_i[idx[IDW-1:0]]) begin
        any_o                = 1'b1;
        winner_o             = idx[IDW-1:0];
        grant_o[idx[IDW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one alu8 between NREQ requesters; IDLE -> EXEC -> RESP per operation
module alu_arbiter
  import nand2cpu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic         CLK100MHZ,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, id_q;
  logic [ALU_W-1:0] a_q, b_q, y_q;
  logic [1:0]       op_q;
  logic             carry_q;

  logic             pick_any;
  logic [IDW-1:0]   pick_winner;
  logic [NREQ-1:0]  pick_grant;
  logic [ALU_W-1:0] win_a, win_b, alu_y;
  logic [1:0]       win_op;
  logic             alu_carry;
  logic             accept;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_winner),
    .grant_o      (pick_grant)
  );

  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        win_a  = bus.req_a[i*ALU_W +: ALU_W];
        win_b  = bus.req_b[i*ALU_W +: ALU_W];
        win_op = bus.req_op[i*2 +: 2];
      end
    end
  end

  assign accept = (state_q == ARB_IDLE) && pick_any;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_any) state_d = ARB_EXEC;
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: if (bus.rsp_ready) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      y_q          <= '0;
      carry_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= win_a;
        b_q          <= win_b;
        op_q         <= win_op;
        id_q         <= pick_winner;
        last_grant_q <= pick_winner;
      end
      if (state_q == ARB_EXEC) begin
        y_q     <= alu_y;
        carry_q <= alu_carry;
      end
    end
  end

  alu8 u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .y_o     (alu_y),
    .carry_o (alu_carry)
  );

  assign bus.req_ready = accept ? pick_grant : '0;
  assign bus.rsp_valid = (state_q == ARB_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_carry = carry_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter
module tb_alu_arbiter;
  import nand2cpu_pkg::*;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] y;
    logic       c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.req_a[id*8 +: 8] = a;
    bus.req_b[id*8 +: 8] = b;
    bus.req_op[id*2 +: 2] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output logic found);
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  // Entered at posedge+1 in IDLE; returns at posedge+1 in IDLE
  task automatic do_op(input vec_t v);
    set_req(v.id, v.a, v.b, v.op);
    bus.req_valid = NREQ'(1 << v.id);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", bus.req_ready, 1 << v.id);
    chk("accept_busy", bus.busy, 0);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_busy", bus.busy, 1);
    chk("exec_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_id", bus.rsp_id, v.id);
    chk("resp_y", bus.rsp_y, v.y);
    chk("resp_carry", bus.rsp_carry, v.c);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_busy", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  logic found;
  int   n3;

  initial begin
    checks = 0;
    errors = 0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    vecs[0] = '{0, 8'd3,   8'd5,   ALU_OP_ADD, 8'd8,   1'b0};
    vecs[1] = '{1, 8'd200, 8'd100, ALU_OP_ADD, 8'd44,  1'b1};
    vecs[2] = '{2, 8'd255, 8'd1,   ALU_OP_ADD, 8'd0,   1'b1};
    vecs[3] = '{3, 8'd10,  8'd3,   ALU_OP_SUB, 8'd7,   1'b0};
    vecs[4] = '{0, 8'd3,   8'd10,  ALU_OP_SUB, 8'd249, 1'b1};
    vecs[5] = '{1, 8'hF0,  8'h3C,  ALU_OP_AND, 8'h30,  1'b0};
    vecs[6] = '{2, 8'hF0,  8'h0F,  ALU_OP_OR,  8'hFF,  1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_y", bus.rsp_y, 0);
    chk("rst_rsp_carry", bus.rsp_carry, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Round robin with all four requesters continuously valid
    do_reset();
    set_req(0, 8'd3,   8'd5,   ALU_OP_ADD);
    set_req(1, 8'd7,   8'd8,   ALU_OP_ADD);
    set_req(2, 8'd15,  8'd1,   ALU_OP_ADD);
    set_req(3, 8'd200, 8'd100, ALU_OP_ADD);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    begin
      logic [7:0] ey[4];
      logic       ec[4];
      ey = '{8'd8, 8'd15, 8'd16, 8'd44};
      ec = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
        wait_rsp("rr_timeout", found);
        chk("rr_id", bus.rsp_id, k);
        chk("rr_y", bus.rsp_y, ey[k]);
        chk("rr_carry", bus.rsp_carry, ec[k]);
      end
    end
    @(negedge clk);
    chk("rr_wrap_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Backpressure: last_grant=3 here
    set_req(1, 8'd100, 8'd27, ALU_OP_ADD);
    set_req(0, 8'd1, 8'd1, ALU_OP_ADD);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 1);
      chk("bp_y", bus.rsp_y, 127);
      chk("bp_busy", bus.busy, 1);
      chk("bp_no_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", bus.rsp_valid, 0);
    chk("bp_release_busy", bus.busy, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Withdrawn request from requester 2 during RESP
    set_req(0, 8'd9, 8'd9, ALU_OP_ADD);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1 bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    chk("wd_resp_id", bus.rsp_id, 0);
    chk("wd_resp_y", bus.rsp_y, 18);
    chk("wd_no_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("wd_no_rsp", bus.rsp_valid, 0);
      chk("wd_idle", bus.busy, 0);
    end
    @(posedge clk); #1;

    // Reset during EXEC
    set_req(1, 8'd1, 8'd2, ALU_OP_ADD);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk("rx_exec_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rx_rsp_valid", bus.rsp_valid, 0);
    chk("rx_busy", bus.busy, 0);
    bus.req_valid = 4'hF;
    #1;
    chk("rx_grant0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Reset during RESP, simultaneous with a handshake
    set_req(2, 8'd50, 8'd60, ALU_OP_ADD);
    bus.req_valid = 4'b0100;
    @(posedge clk); #1 bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_resp_valid", bus.rsp_valid, 1);
    chk("rr_resp_y", bus.rsp_y, 110);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_rst_valid", bus.rsp_valid, 0);
    chk("rr_rst_busy", bus.busy, 0);
    chk("rr_rst_y", bus.rsp_y, 0);
    chk("rr_rst_id", bus.rsp_id, 0);
    bus.req_valid = 4'hF;
    #1;
    chk("rr_rst_grant0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Starvation bound: requester 3 competes with 0..2 re-requesting
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    n3 = 0;
    for (int g = 1; g <= 6 && n3 == 0; g++) begin
      wait_rsp("starve_timeout", found);
      if (found && bus.rsp_id == 2'd3) n3 = g;
    end
    chk("starve_grant_index", n3, 4);
    bus.req_valid = '0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one alu8 instance between NREQ independent requesters using round-robin arbitration. Each requester presents operands and an opcode with a valid/ready handshake. Results return on a single response channel, tagged with the requester ID. The block sits between the CPU-side sequencers or test drivers and the 8-bit ALU datapath, and replaces direct hard-wiring of alu8 operands from the top level.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of the requester ID; derived, not overridden

Ports:
CLK100MHZ  in   1        system clock; all logic on its rising edge
rst        in   1        synchronous, active-high reset
req_valid  in   NREQ     per-requester request valid
req_ready  out  NREQ     per-requester accept; at most one bit high per cycle
req_a      in   NREQ*8   operand A, requester i in bits [8i+7:8i]
req_b      in   NREQ*8   operand B, same packing as req_a
req_op     in   NREQ*2   alu8 opcode, requester i in bits [2i+1:2i]
rsp_valid  out  1        response valid
rsp_ready  in   1        response consumer ready
rsp_id     out  IDW      index of the requester that issued the operation
rsp_y      out  8        alu8 result
rsp_carry  out  1        alu8 carry
busy       out  1        high whenever the FSM state is not IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Encodings come from the package.
- IDLE:
  - Winner = first requester with req_valid=1, scanning from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 combinationally, only in IDLE and only when some req_valid is high.
  - On that edge: latch a/b/op/id of the winner into operand registers; last_grant<=winner; go to EXEC.
- EXEC:
  - Operand registers drive alu8. y/carry are latched into result registers; go to RESP.
  - All req_ready=0.
- RESP:
  - rsp_valid=1; rsp_id/rsp_y/rsp_carry are held stable until the handshake completes.
  - On rsp_valid&rsp_ready: go to IDLE.
  - Backpressure (rsp_ready=0) holds RESP indefinitely; no new request is accepted meanwhile.
- Latency: acceptance edge at cycle N gives rsp_valid=1 in cycle N+2. Peak throughput is one op per 3 cycles. Requests never overlap.
- Requesters may deassert req_valid without being granted. Arbitration is re-evaluated every IDLE cycle with no lock-in.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ grants.
- Opcode 00 = ADD: y = (a+b)[7:0], carry = bit 8. Other opcodes pass through unchanged to alu8 with its existing semantics; no opcode checking.
- Reset values: state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), operand and result registers 0, rsp_valid=0, req_ready=0, rsp_id=0, rsp_y=0, rsp_carry=0, busy=0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, the response is never delivered, and all outputs take reset values on the next cycle.
- A simultaneous rst and handshake gives reset priority.

Decomposition:
- Shared package nand2cpu_pkg:
  - ALU_W=8
  - ALU_OP_ADD=2'b00 plus the other alu8 opcode constants
  - arbiter state typedef/localparams ARB_IDLE, ARB_EXEC, ARB_RESP
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: any, winner index, one-hot grant.
- alu8 is instantiated unchanged.

Test Plan:
1. Reset check: after reset, requester 0 issues ADD a=3, b=5 -> req_ready[0] on the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_y=8, rsp_carry=0.
2. Round-robin: all 4 requesters valid with ADDs (3+5, 7+8, 15+1, 200+100), rsp_ready=1 -> responses in ID order 0,1,2,3 with y=8,15,16,44 and carry 0,0,0,1. Then the next grant is 0 again.
3. Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises -> rsp_* stay stable, busy=1, no req_ready asserted. Releasing rsp_ready gives a one-cycle handshake and a return to IDLE.
4. Withdrawn request: requester 2 pulses req_valid for 1 cycle while in RESP -> never granted, no response with rsp_id=2.
5. Mid-op reset: assert rst in EXEC and, separately, in RESP -> the next cycle has rsp_valid=0, busy=0, and the next grant goes to requester 0.
6. Starvation bound: requester 3 held valid while 0..2 re-request continuously -> requester 3 is granted within 4 grants.
